// File: rtl/ps2_keyboard.sv
// ps2_keyboard
//   PS/2 keyboard receiver. The raw PS/2 clock and data lines are
//   synchronized, the clock is de-glitched, 11-bit frames
//   (start, 8 data LSB first, parity, stop) are deframed and checked.
//   The two most recent accepted bytes are kept for the polled kchar
//   read path.
//
// Parameters
//   FILTER_LEN      consecutive differing samples needed to flip the
//                   filtered clock
//   TIMEOUT_CYCLES  clocks without a filtered falling edge, mid-frame,
//                   before the frame is aborted
//
// Ports
//   clock        system clock (rising edge)
//   reset_n      asynchronous active-low reset
//   ps2_clk      raw PS/2 clock (asynchronous)
//   ps2_data     raw PS/2 data (asynchronous)
//   kchar        {previous byte, latest byte}
//   scancode     latest accepted byte (= kchar[7:0])
//   key_strobe   one-cycle pulse per accepted byte
//   key_release  latest byte was preceded by F0 and is not F0 itself
//   frame_err    one-cycle pulse on a rejected or timed-out frame
//
// Build option
//   PS2_PARITY_CHECK_EN  when defined, frames with even parity are
//                        rejected; otherwise the parity bit is ignored.

module ps2_keyboard #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] kchar,
  output logic [7:0]  scancode,
  output logic        key_strobe,
  output logic        key_release,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // ---------------------------------------------------------------
  // Two-flop synchronizers; bit 0 = clock line, bit 1 = data line.
  // Both reset high, matching an idle bus.
  // ---------------------------------------------------------------
  logic [1:0] raw_in;
  logic [1:0] synced;
  assign raw_in = {ps2_data, ps2_clk};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
        end else begin
          meta_reg <= raw_in[gi];
          sync_reg <= meta_reg;
        end
      end
      assign synced[gi] = sync_reg;
    end
  endgenerate

  logic data_bit;
  assign data_bit = synced[1];

  // ---------------------------------------------------------------
  // Clock filter: fclk flips only after FILTER_LEN consecutive
  // synchronized samples disagree with it. fclk_d_reg delays fclk by
  // one clock so the falling edge is seen the cycle after the flip.
  // ---------------------------------------------------------------
  logic          fclk_reg;
  logic          fclk_d_reg;
  logic [FW-1:0] filt_cnt_reg;
  logic          fall;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fclk_reg     <= 1'b1;
      fclk_d_reg   <= 1'b1;
      filt_cnt_reg <= '0;
    end else begin
      fclk_d_reg <= fclk_reg;
      if (synced[0] != fclk_reg) begin
        if (filt_cnt_reg == FW'(FILTER_LEN - 1)) begin
          fclk_reg     <= ~fclk_reg;
          filt_cnt_reg <= '0;
        end else begin
          filt_cnt_reg <= filt_cnt_reg + 1'b1;
        end
      end else begin
        filt_cnt_reg <= '0;
      end
    end
  end

  assign fall = fclk_d_reg & ~fclk_reg;

  // ---------------------------------------------------------------
  // Frame FSM, watchdog and output registers
  // ---------------------------------------------------------------
  state_t        state_reg,    state_next;
  logic [2:0]    bit_cnt_reg,  bit_cnt_next;
  logic [7:0]    shift_reg,    shift_next;
  logic [WW-1:0] wd_reg,       wd_next;
  logic [15:0]   kchar_reg,    kchar_next;
  logic          release_reg,  release_next;
  logic          strobe_reg,   strobe_next;
  logic          err_reg,      err_next;
  logic          parity_ok;

`ifdef PS2_PARITY_CHECK_EN
  logic parity_reg, parity_next;
  // Odd parity over data + parity bit.
  assign parity_ok = (^shift_reg) ^ parity_reg;
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      wd_reg      <= '0;
      kchar_reg   <= '0;
      release_reg <= 1'b0;
      strobe_reg  <= 1'b0;
      err_reg     <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      wd_reg      <= wd_next;
      kchar_reg   <= kchar_next;
      release_reg <= release_next;
      strobe_reg  <= strobe_next;
      err_reg     <= err_next;
`ifdef PS2_PARITY_CHECK_EN
      parity_reg  <= parity_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    wd_next      = '0;
    kchar_next   = kchar_reg;
    release_next = release_reg;
    strobe_next  = 1'b0;
    err_next     = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    parity_next  = parity_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (fall && !data_bit) begin
          state_next   = DATA;
          bit_cnt_next = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_next   = {data_bit, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == 3'd7) state_next = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
`ifdef PS2_PARITY_CHECK_EN
          parity_next = data_bit;
`endif
          state_next = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_next = IDLE;
          if (data_bit && parity_ok) begin
            kchar_next   = {kchar_reg[7:0], shift_reg};
            release_next = (shift_reg == 8'hF0) ? 1'b0
                                                : (kchar_reg[7:0] == 8'hF0);
            strobe_next  = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Watchdog: a falling edge always wins over expiry in the same cycle.
    if (state_reg != IDLE && !fall) begin
      if (wd_reg == WW'(TIMEOUT_CYCLES - 1)) begin
        state_next = IDLE;
        err_next   = 1'b1;
      end else begin
        wd_next = wd_reg + 1'b1;
      end
    end
  end

  assign kchar       = kchar_reg;
  assign scancode    = kchar_reg[7:0];
  assign key_strobe  = strobe_reg;
  assign key_release = release_reg;
  assign frame_err   = err_reg;

endmodule
